// File: rtl/pwm_timer_pkg.sv
// Shared constants and types for the multi-channel PWM timer.
package pwm_timer_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 4;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM channel: active compare/polarity registers, compare against the shared
// counter, and the registered output pin.
module pwm_compare_channel
  import pwm_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             apply_i,
  input  logic [WIDTH-1:0] cmp_shadow_i,
  input  logic             pol_shadow_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             chan_en_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] cmp_q;
  logic             pol_q;
  logic             pwm_q;
  logic             raw;
  logic             pwm_d;

  always_comb begin
    raw = (count_i < cmp_q);
    // A stopped timer or a disabled channel drives the idle level.
    if (enable_i && chan_en_i) begin
      pwm_d = raw ^ pol_q;
    end else begin
      pwm_d = pol_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q <= '0;
      pol_q <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      if (apply_i) begin
        cmp_q <= cmp_shadow_i;
        pol_q <= pol_shadow_i;
      end
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: shared prescaler and edge/center-aligned counter,
// double-buffered configuration applied only at period boundaries.
module pwm_timer_multi
  import pwm_timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      load_req_i,
  input  logic                      mode_i,
  input  logic [WIDTH-1:0]          prescaler_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] compare_i,
  input  logic [CHANNELS-1:0]       polarity_i,
  input  logic [CHANNELS-1:0]       chan_enable_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      period_event_o,
  output logic [WIDTH-1:0]          count_value_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Shadow (written by the register interface) and active (used by the counter).
  logic                      mode_sh_q;
  logic [WIDTH-1:0]          psc_sh_q;
  logic [WIDTH-1:0]          per_sh_q;
  logic [CHANNELS*WIDTH-1:0] cmp_sh_q;
  logic [CHANNELS-1:0]       pol_sh_q;
  logic                      pending_q, pending_d;
  logic                      mode_q;
  logic [WIDTH-1:0]          psc_act_q;
  logic [WIDTH-1:0]          per_act_q;

  logic [WIDTH-1:0]          psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  dir_e                      dir_q, dir_d;
  logic                      event_q;
  logic                      tick;
  logic                      update;
  logic                      apply;

  always_comb begin
    tick      = (psc_cnt_q == psc_act_q);
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    update    = 1'b0;
    if (!enable_i) begin
      psc_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = DIR_UP;
    end else begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + ONE;
      if (tick) begin
        if (mode_q == MODE_EDGE) begin
          dir_d = DIR_UP;
          if (cnt_q >= per_act_q) begin
            cnt_d  = '0;
            update = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (per_act_q == '0) begin
          cnt_d  = '0;
          dir_d  = DIR_UP;
          update = 1'b1;
        end else if (dir_q == DIR_UP) begin
          // Turn around at the top; the top value is held for a single tick.
          if (cnt_q >= per_act_q) begin
            cnt_d = per_act_q - ONE;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (cnt_q == '0) begin
          cnt_d  = ONE;
          dir_d  = DIR_UP;
          update = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // Stopped timer tracks shadow continuously; running timer only at boundaries.
  // A load coinciding with a boundary keeps pending set so it lands next period.
  always_comb begin
    apply = !enable_i || (update && pending_q);
    if (load_req_i) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_sh_q <= MODE_EDGE;
      psc_sh_q  <= '0;
      per_sh_q  <= '0;
      cmp_sh_q  <= '0;
      pol_sh_q  <= '0;
      pending_q <= 1'b0;
      mode_q    <= MODE_EDGE;
      psc_act_q <= '0;
      per_act_q <= '0;
      psc_cnt_q <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      event_q   <= 1'b0;
    end else begin
      if (load_req_i) begin
        mode_sh_q <= mode_i;
        psc_sh_q  <= prescaler_i;
        per_sh_q  <= period_i;
        cmp_sh_q  <= compare_i;
        pol_sh_q  <= polarity_i;
      end
      if (apply) begin
        mode_q    <= mode_sh_q;
        psc_act_q <= psc_sh_q;
        per_act_q <= per_sh_q;
      end
      pending_q <= pending_d;
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      event_q   <= update;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_compare_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i),
      .apply_i      (apply),
      .cmp_shadow_i (cmp_sh_q[i*WIDTH +: WIDTH]),
      .pol_shadow_i (pol_sh_q[i]),
      .count_i      (cnt_q),
      .chan_en_i    (chan_enable_i[i]),
      .pwm_o        (pwm_o[i])
    );
  end

  // Event is registered so it lines up with the counter restart and PwmOut.
  assign period_event_o = event_q;
  assign count_value_o  = cnt_q;

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi: edge/center counting, prescaler, compare
// extremes, polarity, double-buffered reloads, reset and channel disable.
module tb_pwm_timer_multi;
  import pwm_timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_req;
  logic        mode;
  logic [15:0] prescaler;
  logic [15:0] period;
  logic [63:0] compare;
  logic [3:0]  polarity;
  logic [3:0]  chan_enable;
  logic [3:0]  pwm;
  logic        period_event;
  logic [15:0] count_value;

  int n_checks;
  int n_pass;
  int s [8];

  pwm_timer_multi #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .load_req_i     (load_req),
    .mode_i         (mode),
    .prescaler_i    (prescaler),
    .period_i       (period),
    .compare_i      (compare),
    .polarity_i     (polarity),
    .chan_enable_i  (chan_enable),
    .pwm_o          (pwm),
    .period_event_o (period_event),
    .count_value_o  (count_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop, load a configuration, let it reach the active registers, then run.
  // The next rising edge after return is the first enabled edge (k = 0).
  task automatic start_cfg(input logic m, input logic [15:0] psc, input logic [15:0] per,
                           input logic [63:0] cmp, input logic [3:0] pol);
    enable    = 1'b0;
    mode      = m;
    prescaler = psc;
    period    = per;
    compare   = cmp;
    polarity  = pol;
    load_req  = 1'b1;
    step();
    load_req  = 1'b0;
    step();
    enable    = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    s           = '{0, 1, 2, 3, 4, 3, 2, 1};
    rst_n       = 1'b0;
    enable      = 1'b0;
    load_req    = 1'b0;
    mode        = MODE_EDGE;
    prescaler   = '0;
    period      = '0;
    compare     = '0;
    polarity    = '0;
    chan_enable = 4'hF;
    #3;
    check("rst_pwm", pwm, 0);
    check("rst_cnt", count_value, 0);
    check("rst_evt", period_event, 0);
    step();
    step();
    rst_n = 1'b1;

    // 1: edge, psc 0, period 9; compares 3, 0, 10 (>period), 5
    start_cfg(MODE_EDGE, 16'd0, 16'd9, {16'd5, 16'd10, 16'd0, 16'd3}, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      step();
      check("e_cnt", count_value, (k + 1) % 10);
      check("e_pwm0", pwm[0], ((k % 10) < 3));
      check("e_pwm1", pwm[1], 0);
      check("e_pwm2", pwm[2], 1);
      check("e_pwm3", pwm[3], ((k % 10) < 5));
      check("e_evt", period_event, ((k % 10) == 9));
    end

    // 2: prescaler 2, period 4 -> step every 3 clocks, 15-clock period
    start_cfg(MODE_EDGE, 16'd2, 16'd4, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0000);
    for (int k = 0; k < 30; k++) begin
      step();
      check("p_cnt", count_value, ((k + 1) / 3) % 5);
      check("p_evt", period_event, ((k % 15) == 14));
      check("p_pwm0", pwm[0], (((k / 3) % 5) < 2));
    end

    // 3: center, period 4; count 0,1,2,3,4,3,2,1,...
    start_cfg(MODE_CENTER, 16'd0, 16'd4, {16'd4, 16'd0, 16'd5, 16'd2}, 4'b0000);
    for (int k = 0; k < 24; k++) begin
      step();
      check("c_cnt", count_value, s[(k + 1) % 8]);
      check("c_pwm0", pwm[0], (s[k % 8] < 2));
      check("c_pwm1", pwm[1], 1);
      check("c_pwm2", pwm[2], 0);
      check("c_pwm3", pwm[3], (s[k % 8] < 4));
      check("c_evt", period_event, ((k % 8) == 0) && (k > 0));
    end

    // 4: compare 0 / period+1 with mixed polarity, then live channel disable
    start_cfg(MODE_EDGE, 16'd0, 16'd4, {16'd5, 16'd0, 16'd5, 16'd0}, 4'b1100);
    for (int k = 0; k < 8; k++) begin
      step();
      check("x_pwm", pwm, 4'b0110);
    end
    chan_enable = 4'b0101;
    step();
    check("x_chen", pwm, 4'b1100);
    chan_enable = 4'hF;
    step();
    check("x_chen_back", pwm, 4'b0110);
    enable = 1'b0;
    step();
    check("x_idle_pwm", pwm, 4'b1100);
    check("x_idle_cnt", count_value, 0);

    // 5: reload period 9->4 mid-period, then a reload on the event clock (->6)
    start_cfg(MODE_EDGE, 16'd0, 16'd9, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      step();
      if (k < 9) begin
        check("r_cnt", count_value, (k + 1) % 10);
        check("r_evt", period_event, 0);
      end else if (k < 24) begin
        check("r_cnt", count_value, (k - 9) % 5);
        check("r_evt", period_event, ((k - 9) % 5) == 0);
      end else begin
        check("r_cnt", count_value, (k - 24) % 7);
        check("r_evt", period_event, ((k - 24) % 7) == 0);
      end
      if (k == 3) begin
        period   = 16'd4;
        load_req = 1'b1;
      end else if (k == 18) begin
        period   = 16'd6;
        load_req = 1'b1;
      end else begin
        load_req = 1'b0;
      end
    end

    // 6: asynchronous reset mid-count, then restart from cleared config
    start_cfg(MODE_EDGE, 16'd0, 16'd9, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0000);
    step();
    step();
    check("a_cnt_pre", count_value, 2);
    check("a_pwm_pre", pwm[0], 1);
    rst_n = 1'b0;
    #1;
    check("a_cnt_rst", count_value, 0);
    check("a_pwm_rst", pwm, 0);
    check("a_evt_rst", period_event, 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("a_cnt_hold", count_value, 0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("a_cnt_run", count_value, 0);
      check("a_pwm_run", pwm, 0);
      check("a_evt_run", period_event, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
